// File: rtl/controller_pkg.sv
// Shared types and encodings for the multicycle ARM controller: FSM states, ALU ops,
// instruction field codes and datapath mux selects.
package controller_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StExecR,
    StExecI,
    StAluWb,
    StBranch
  } state_t;

  // ALU operation codes; truncated/extended to ALUCTRL_W at the output.
  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOrr = 3'b011;
  localparam logic [2:0] AluEor = 3'b100;

  localparam logic [1:0] OpDp  = 2'b00;
  localparam logic [1:0] OpMem = 2'b01;
  localparam logic [1:0] OpBr  = 2'b10;

  localparam logic [3:0] CmdAnd = 4'b0000;
  localparam logic [3:0] CmdEor = 4'b0001;
  localparam logic [3:0] CmdSub = 4'b0010;
  localparam logic [3:0] CmdAdd = 4'b0100;
  localparam logic [3:0] CmdTst = 4'b1000;
  localparam logic [3:0] CmdCmp = 4'b1010;
  localparam logic [3:0] CmdOrr = 4'b1100;

  localparam logic [3:0] CondEq = 4'b0000;
  localparam logic [3:0] CondNe = 4'b0001;
  localparam logic [3:0] CondCs = 4'b0010;
  localparam logic [3:0] CondCc = 4'b0011;
  localparam logic [3:0] CondMi = 4'b0100;
  localparam logic [3:0] CondPl = 4'b0101;
  localparam logic [3:0] CondVs = 4'b0110;
  localparam logic [3:0] CondVc = 4'b0111;
  localparam logic [3:0] CondHi = 4'b1000;
  localparam logic [3:0] CondLs = 4'b1001;
  localparam logic [3:0] CondGe = 4'b1010;
  localparam logic [3:0] CondLt = 4'b1011;
  localparam logic [3:0] CondGt = 4'b1100;
  localparam logic [3:0] CondLe = 4'b1101;
  localparam logic [3:0] CondAl = 4'b1110;
  localparam logic [3:0] CondNv = 4'b1111;

  localparam logic [1:0] ResAluOut    = 2'd0;
  localparam logic [1:0] ResReadData  = 2'd1;
  localparam logic [1:0] ResAluResult = 2'd2;

  localparam logic [1:0] SrcARn = 2'd0;
  localparam logic [1:0] SrcAPc = 2'd1;

  localparam logic [1:0] SrcBReg  = 2'd0;
  localparam logic [1:0] SrcBImm  = 2'd1;
  localparam logic [1:0] SrcBFour = 2'd2;

  // Only arithmetic ops produce meaningful carry/overflow.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == AluAdd) || (op == AluSub);
  endfunction

endpackage

// File: rtl/cond_check_unit.sv
// Combinational ARM condition-field evaluator against a {N,Z,C,V} flag set.
module cond_check_unit
  import controller_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_ex_o
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags_i;

  always_comb begin
    cond_ex_o = 1'b0;
    case (cond_i)
      CondEq: cond_ex_o = z;
      CondNe: cond_ex_o = ~z;
      CondCs: cond_ex_o = c;
      CondCc: cond_ex_o = ~c;
      CondMi: cond_ex_o = n;
      CondPl: cond_ex_o = ~n;
      CondVs: cond_ex_o = v;
      CondVc: cond_ex_o = ~v;
      CondHi: cond_ex_o = c & ~z;
      CondLs: cond_ex_o = ~c | z;
      CondGe: cond_ex_o = ~(n ^ v);
      CondLt: cond_ex_o = n ^ v;
      CondGt: cond_ex_o = ~z & ~(n ^ v);
      CondLe: cond_ex_o = z | (n ^ v);
      CondAl: cond_ex_o = 1'b1;
      CondNv: cond_ex_o = 1'b0;
      default: cond_ex_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller_unit.sv
// Multicycle ARM control FSM: sequences fetch/decode/execute/memory/writeback, decodes
// DP/LDR/STR/B, holds the NZCV flag register and the latched condition result.
module multicycle_controller_unit
  import controller_pkg::*;
#(
  parameter int unsigned ALUCTRL_W = 2,
  parameter bit          EN_CMP    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:12]         instr,
  input  logic [3:0]           ALUFlags,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic [1:0]           RegSrc,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [1:0]           ResultSrc
);

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       condex_q, condex_d;

  logic [1:0] op;
  logic       i_bit, s_bit, rd_is_pc;
  logic [3:0] cmd;
  logic       cond_ex;

  assign op       = instr[27:26];
  assign i_bit    = instr[25];
  assign cmd      = instr[24:21];
  assign s_bit    = instr[20];  // doubles as L for memory ops
  assign rd_is_pc = (instr[15:12] == 4'd15);

  // Rn selection happens in the datapath; the controller never looks at it.
  logic unused_rn;
  assign unused_rn = ^instr[19:16];

  cond_check_unit u_cond_check (
    .cond_i   (instr[31:28]),
    .flags_i  (flags_q),
    .cond_ex_o(cond_ex)
  );

  logic       dp_legal, dp_regw;
  logic [2:0] dp_op;

  always_comb begin
    dp_legal = 1'b0;
    dp_regw  = 1'b0;
    dp_op    = AluAdd;
    case (cmd)
      CmdAdd: begin dp_legal = 1'b1; dp_regw = 1'b1; dp_op = AluAdd; end
      CmdSub: begin dp_legal = 1'b1; dp_regw = 1'b1; dp_op = AluSub; end
      CmdAnd: begin dp_legal = 1'b1; dp_regw = 1'b1; dp_op = AluAnd; end
      CmdOrr: begin dp_legal = 1'b1; dp_regw = 1'b1; dp_op = AluOrr; end
      CmdEor: begin dp_legal = (ALUCTRL_W >= 3); dp_regw = 1'b1; dp_op = AluEor; end
      // Compare/test are flag-only, so without S they do nothing and are rejected.
      CmdCmp: begin dp_legal = EN_CMP && s_bit; dp_op = AluSub; end
      CmdTst: begin dp_legal = EN_CMP && s_bit; dp_op = AluAnd; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        case (op)
          OpMem:   state_d = StMemAdr;
          OpDp:    state_d = !dp_legal ? StFetch : (i_bit ? StExecI : StExecR);
          OpBr:    state_d = StBranch;
          default: state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = s_bit ? StMemRd : StMemWr;
      StMemRd:  state_d = StMemWb;
      StMemWb:  state_d = StFetch;
      StMemWr:  state_d = StFetch;
      StExecR:  state_d = StAluWb;
      StExecI:  state_d = StAluWb;
      StAluWb:  state_d = StFetch;
      StBranch: state_d = StFetch;
      default:  state_d = StFetch;
    endcase
  end

  // Condition is frozen at decode so this instruction's own flag update cannot gate its writes.
  always_comb begin
    condex_d = (state_q == StDecode) ? cond_ex : condex_q;
    flags_d  = flags_q;
    if ((state_q == StExecR || state_q == StExecI) && condex_q && s_bit) begin
      flags_d[3:2] = ALUFlags[3:2];
      if (is_arith(dp_op)) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StFetch;
      flags_q  <= 4'b0000;
      condex_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      condex_q <= condex_d;
    end
  end

  logic [2:0] alu_sel;

  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    RegSrc    = {(op == OpMem) && !s_bit, op == OpBr};
    ImmSrc    = op;
    ALUSrcA   = SrcARn;
    ALUSrcB   = SrcBReg;
    ResultSrc = ResAluOut;
    alu_sel   = AluAdd;
    unique case (state_q)
      StFetch: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcA   = SrcAPc;
        ALUSrcB   = SrcBFour;
        ResultSrc = ResAluResult;
      end
      StDecode: begin
        ALUSrcA   = SrcAPc;
        ALUSrcB   = SrcBFour;
        ResultSrc = ResAluResult;
      end
      StMemAdr: ALUSrcB = SrcBImm;
      StMemRd:  AdrSrc = 1'b1;
      StMemWb: begin
        ResultSrc = ResReadData;
        RegWrite  = condex_q;
        PCWrite   = condex_q & rd_is_pc;
      end
      StMemWr: begin
        AdrSrc   = 1'b1;
        MemWrite = condex_q;
      end
      StExecR: begin
        ALUSrcB = SrcBReg;
        alu_sel = dp_op;
      end
      StExecI: begin
        ALUSrcB = SrcBImm;
        alu_sel = dp_op;
      end
      StAluWb: begin
        ResultSrc = ResAluOut;
        RegWrite  = condex_q & dp_regw;
        PCWrite   = condex_q & dp_regw & rd_is_pc;
      end
      StBranch: begin
        ALUSrcB   = SrcBImm;
        ResultSrc = ResAluResult;
        PCWrite   = condex_q;
      end
      default: ;
    endcase
    ALUControl = ALUCTRL_W'(alu_sel);
    if (rst) begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      RegSrc     = 2'b00;
      ImmSrc     = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUControl = '0;
      ResultSrc  = 2'b00;
    end
  end

endmodule
